// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - synchronous data memory with ready/valid handshake and wait states
//
// Purpose: word-addressed data memory for the MEM stage. A request is accepted
// in IDLE, held for WAIT_CYCLES cycles, then performed in a single ACCESS
// cycle that pulses sig_valid (and sig_error for addresses >= DEPTH).
// Optional feature macro: DMEM_BYTE_STROBE_EN (adds sig_byte_en write strobes).
//
// Ports:
//   clock, reset       rising-edge clock, synchronous active-high reset
//   sig_enable_read    read request, sampled only while sig_ready=1
//   sig_enable_write   write request, sampled only while sig_ready=1
//   AddressBus         word address (full-width range check against DEPTH)
//   InputBus           write data
//   sig_byte_en        per-byte write strobes (DMEM_BYTE_STROBE_EN only)
//   OutputBus          registered read data, held until the next completed read
//   sig_ready          1 while idle and able to accept a request
//   sig_valid          one-cycle pulse when an access completes
//   sig_error          one-cycle pulse with sig_valid for an out-of-range address
module data_memory_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sig_enable_read,
  input  logic              sig_enable_write,
  input  logic [ADDR_W-1:0] AddressBus,
  input  logic [DATA_W-1:0] InputBus,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [DATA_W/8-1:0] sig_byte_en,
`endif
  output logic [DATA_W-1:0] OutputBus,
  output logic              sig_ready,
  output logic              sig_valid,
  output logic              sig_error
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NB    = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              op_rd_q, op_rd_d;
  logic              op_wr_q, op_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [NB-1:0]     be_q, be_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              valid_q, valid_d;
  logic              error_q, error_d;

  logic [NB-1:0]     be_in;
  logic              in_range;
  logic              mem_we;
  logic [IDX_W-1:0]  idx;

  logic [DATA_W-1:0] mem [DEPTH];

`ifdef DMEM_BYTE_STROBE_EN
  assign be_in = sig_byte_en;
`else
  assign be_in = '1;
`endif

  // Full-width compare so high address bits never alias onto a legal word.
  assign in_range = (addr_q < ADDR_W'(DEPTH));
  assign idx      = addr_q[IDX_W-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_rd_d = op_rd_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    valid_d = 1'b0;
    error_d = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sig_enable_read || sig_enable_write) begin
          // Read has priority; a simultaneous write is dropped.
          op_rd_d = sig_enable_read;
          op_wr_d = sig_enable_write && !sig_enable_read;
          addr_d  = AddressBus;
          wdata_d = InputBus;
          be_d    = be_in;
          if (WAIT_CYCLES == 0) begin
            state_d = S_ACCESS;
            cnt_d   = 4'd0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        valid_d = 1'b1;
        error_d = !in_range;
        state_d = S_IDLE;
        if (op_rd_q) begin
          rdata_d = in_range ? mem[idx] : '0;
        end
        // Gated by reset so an aborted access never touches the array.
        mem_we = op_wr_q && in_range && !reset;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      op_rd_q <= 1'b0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_rd_q <= op_rd_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  // Storage is not reset; contents survive a reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (be_q[i]) begin
          mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign OutputBus = rdata_q;
  assign sig_ready = (state_q == S_IDLE);
  assign sig_valid = valid_q;
  assign sig_error = error_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - directed self-checking bench for data_memory_ctrl
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        rst, ren, wen;
  logic [31:0] addr, din, out;
  logic        rdy, vld, err;

  logic        rst3, ren3, wen3;
  logic [31:0] addr3, din3, out3;
  logic        rdy3, vld3, err3;

`ifdef DMEM_BYTE_STROBE_EN
  logic [3:0]  be_drv = 4'hF;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_memory_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_CYCLES(1)) dut (
    .clock(clk), .reset(rst),
    .sig_enable_read(ren), .sig_enable_write(wen),
    .AddressBus(addr), .InputBus(din),
`ifdef DMEM_BYTE_STROBE_EN
    .sig_byte_en(be_drv),
`endif
    .OutputBus(out), .sig_ready(rdy), .sig_valid(vld), .sig_error(err)
  );

  data_memory_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_CYCLES(3)) dut3 (
    .clock(clk), .reset(rst3),
    .sig_enable_read(ren3), .sig_enable_write(wen3),
    .AddressBus(addr3), .InputBus(din3),
`ifdef DMEM_BYTE_STROBE_EN
    .sig_byte_en(4'hF),
`endif
    .OutputBus(out3), .sig_ready(rdy3), .sig_valid(vld3), .sig_error(err3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One WAIT_CYCLES=1 access on dut; the bus carries noise while busy.
  // vh/rh bit i = sig_valid/sig_ready sampled after edge T0+i.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, output logic [2:0] vh,
                        output logic [2:0] rh, output logic e,
                        output logic [31:0] o, output logic va);
    ren = rd; wen = wr; addr = a; din = d;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 0) begin
        ren = 1'b1; wen = 1'b1; addr = ~a; din = ~d;
      end
      vh[i] = vld;
      rh[i] = rdy;
      if (i == 2) begin
        e = err; o = out; ren = 1'b0; wen = 1'b0;
      end
    end
    tick();
    va = vld | err;
  endtask

  task automatic test_reset();
    rst = 1'b1; ren = 1'b0; wen = 1'b0; addr = '0; din = '0;
    tick(); tick();
    checks++; if (out !== 32'h0) begin failures++; $display("FAIL reset_out: got %h expected %h", out, 32'h0); end
    checks++; if (vld !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", vld); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_error: got %b expected 0", err); end
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", rdy); end
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    logic [2:0] vh, rh; logic e, va; logic [31:0] o;
    access(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, vh, rh, e, o, va);
    checks++; if (vh !== 3'b100) begin failures++; $display("FAIL wr_valid_timing: got %b expected 100", vh); end
    checks++; if (rh !== 3'b100) begin failures++; $display("FAIL wr_ready_timing: got %b expected 100", rh); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL wr_error: got %b expected 0", e); end
    checks++; if (o !== 32'h0) begin failures++; $display("FAIL wr_keeps_out: got %h expected %h", o, 32'h0); end
    checks++; if (va !== 1'b0) begin failures++; $display("FAIL wr_pulse_len: got %b expected 0", va); end
    access(1'b1, 1'b0, 32'd5, 32'h0, vh, rh, e, o, va);
    checks++; if (vh !== 3'b100) begin failures++; $display("FAIL rd_valid_timing: got %b expected 100", vh); end
    checks++; if (rh !== 3'b100) begin failures++; $display("FAIL rd_ready_timing: got %b expected 100", rh); end
    checks++; if (o !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data5: got %h expected %h", o, 32'hDEADBEEF); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL rd_error: got %b expected 0", e); end
  endtask

  task automatic test_read_priority();
    logic [2:0] vh, rh; logic e, va; logic [31:0] o;
    access(1'b0, 1'b1, 32'd3, 32'h11, vh, rh, e, o, va);
    access(1'b1, 1'b1, 32'd3, 32'h99, vh, rh, e, o, va);
    checks++; if (o !== 32'h11) begin failures++; $display("FAIL rw_same_out: got %h expected %h", o, 32'h11); end
    access(1'b1, 1'b0, 32'd3, 32'h0, vh, rh, e, o, va);
    checks++; if (o !== 32'h11) begin failures++; $display("FAIL rw_write_dropped: got %h expected %h", o, 32'h11); end
  endtask

  task automatic test_out_of_range();
    logic [2:0] vh, rh; logic e, va; logic [31:0] o;
    access(1'b0, 1'b1, 32'd0, 32'hCAFE0000, vh, rh, e, o, va);
    access(1'b0, 1'b1, 32'd256, 32'h55, vh, rh, e, o, va);
    checks++; if (vh !== 3'b100) begin failures++; $display("FAIL oor_wr_valid: got %b expected 100", vh); end
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL oor_wr_error: got %b expected 1", e); end
    checks++; if (va !== 1'b0) begin failures++; $display("FAIL oor_err_pulse_len: got %b expected 0", va); end
    checks++; if (o !== 32'h11) begin failures++; $display("FAIL oor_wr_keeps_out: got %h expected %h", o, 32'h11); end
    access(1'b1, 1'b0, 32'd0, 32'h0, vh, rh, e, o, va);
    checks++; if (o !== 32'hCAFE0000) begin failures++; $display("FAIL oor_mem0_intact: got %h expected %h", o, 32'hCAFE0000); end
    access(1'b1, 1'b0, 32'h100, 32'h0, vh, rh, e, o, va);
    checks++; if (o !== 32'h0) begin failures++; $display("FAIL oor_rd_zero: got %h expected %h", o, 32'h0); end
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL oor_rd_error: got %b expected 1", e); end
    access(1'b0, 1'b1, 32'h80000003, 32'h77, vh, rh, e, o, va);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL oor_high_error: got %b expected 1", e); end
    access(1'b1, 1'b0, 32'd3, 32'h0, vh, rh, e, o, va);
    checks++; if (o !== 32'h11) begin failures++; $display("FAIL oor_no_alias: got %h expected %h", o, 32'h11); end
    access(1'b0, 1'b1, 32'd255, 32'h0000FEED, vh, rh, e, o, va);
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL last_wr_error: got %b expected 0", e); end
    access(1'b1, 1'b0, 32'd255, 32'h0, vh, rh, e, o, va);
    checks++; if (o !== 32'h0000FEED) begin failures++; $display("FAIL last_rd_data: got %h expected %h", o, 32'h0000FEED); end
  endtask

  task automatic test_wait3_reset_abort();
    logic seen; logic lat_early;
    rst3 = 1'b1; ren3 = 1'b0; wen3 = 1'b0; addr3 = '0; din3 = '0;
    tick(); tick();
    rst3 = 1'b0;
    wen3 = 1'b1; addr3 = 32'd7; din3 = 32'h12;
    tick();
    wen3 = 1'b0;
    lat_early = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      lat_early = lat_early | vld3;
    end
    checks++; if (lat_early !== 1'b0) begin failures++; $display("FAIL w3_early_valid: got %b expected 0", lat_early); end
    tick();
    checks++; if (vld3 !== 1'b1) begin failures++; $display("FAIL w3_valid_at_4: got %b expected 1", vld3); end
    tick();
    wen3 = 1'b1; addr3 = 32'd7; din3 = 32'hAA;
    tick();
    wen3 = 1'b0;
    tick();
    rst3 = 1'b1;
    tick();
    rst3 = 1'b0;
    checks++; if (rdy3 !== 1'b1) begin failures++; $display("FAIL w3_abort_ready: got %b expected 1", rdy3); end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | vld3;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL w3_abort_no_valid: got %b expected 0", seen); end
    ren3 = 1'b1; addr3 = 32'd7;
    tick();
    ren3 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (vld3 !== 1'b1) begin failures++; $display("FAIL w3_rd_valid: got %b expected 1", vld3); end
    checks++; if (out3 !== 32'h12) begin failures++; $display("FAIL w3_abort_mem: got %h expected %h", out3, 32'h12); end
  endtask

`ifdef DMEM_BYTE_STROBE_EN
  task automatic test_byte_strobe();
    logic [2:0] vh, rh; logic e, va; logic [31:0] o;
    be_drv = 4'hF;
    access(1'b0, 1'b1, 32'd9, 32'h12345678, vh, rh, e, o, va);
    be_drv = 4'b0101;
    access(1'b0, 1'b1, 32'd9, 32'hAABBCCDD, vh, rh, e, o, va);
    be_drv = 4'b0000;
    access(1'b0, 1'b1, 32'd9, 32'hFFFFFFFF, vh, rh, e, o, va);
    checks++; if (vh !== 3'b100) begin failures++; $display("FAIL be_zero_valid: got %b expected 100", vh); end
    be_drv = 4'b0000;
    access(1'b1, 1'b0, 32'd9, 32'h0, vh, rh, e, o, va);
    checks++; if (o !== 32'h12BB56DD) begin failures++; $display("FAIL be_merge: got %h expected %h", o, 32'h12BB56DD); end
    be_drv = 4'hF;
  endtask
`endif

  initial begin
    rst3 = 1'b1; ren3 = 1'b0; wen3 = 1'b0; addr3 = '0; din3 = '0;
    test_reset();
    test_write_read();
    test_read_priority();
    test_out_of_range();
    test_wait3_reset_abort();
`ifdef DMEM_BYTE_STROBE_EN
    test_byte_strobe();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
